// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide issue controller.
// Optional watchdog is enabled with the MULTDIV_TIMEOUT_EN macro.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_t;

    localparam int MULT_EXC_CODE_DEF  = 4;
    localparam int DIV_EXC_CODE_DEF   = 5;
    localparam int RSTATUS_REG_DEF    = 30;
    localparam int TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/multdiv_watchdog.sv
// Saturating cycle counter that flags when the multdiv unit has been waited on too long.
// Only instantiated when MULTDIV_TIMEOUT_EN is defined.
module multdiv_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    output logic o_expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    // Counter is zero whenever the controller is not waiting, so it restarts per op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_run) begin
            r_count <= '0;
        end else if (r_count != CW'(LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Asserted during the LIMIT-th consecutive waiting cycle.
    assign o_expired = i_run && (r_count >= CW'(LIMIT - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issues MUL/DIV ops to the multi-cycle unit, stalls until ready, then writes back once.
// Define MULTDIV_TIMEOUT_EN to add a watchdog that forces an exception writeback.
import multdiv_pkg::*;

module multdiv_issue_ctrl #(
    parameter int DATA_W         = 32,
    parameter int REG_W          = 5,
    parameter int RSTATUS_REG    = RSTATUS_REG_DEF,
    parameter int MULT_EXC_CODE  = MULT_EXC_CODE_DEF,
    parameter int DIV_EXC_CODE   = DIV_EXC_CODE_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              op_valid,
    input  logic              op_is_div,
    input  logic [REG_W-1:0]  op_rd,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] md_operand_a,
    output logic [DATA_W-1:0] md_operand_b,
    output logic              md_ctrl_mult,
    output logic              md_ctrl_div,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    input  logic              md_result_rdy,
    output logic              stall,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    md_state_t         r_state;
    md_state_t         w_next_state;
    logic              r_is_div;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [REG_W-1:0]  r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              w_accept;
    logic              w_capture;
    logic              w_exc;
    logic              w_timeout;

`ifdef MULTDIV_TIMEOUT_EN
    multdiv_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clock),
        .rst_n    (reset_n),
        .i_run    (r_state == ST_WAIT),
        .o_expired(w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && op_valid;

    // Ready is only looked at in WAIT; a ready left over from the previous op during START is ignored.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_exc        = md_exception;
        case (r_state)
            ST_IDLE:  if (op_valid) w_next_state = ST_START;
            ST_START: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (md_result_rdy) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_DONE;
                end else if (w_timeout) begin
                    w_capture    = 1'b1;
                    w_exc        = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_is_div <= 1'b0;
            r_rd     <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
        end else if (w_accept) begin
            r_is_div <= op_is_div;
            r_rd     <= op_rd;
            r_op_a   <= op_a;
            r_op_b   <= op_b;
        end
    end

    // Writeback fields are resolved at capture so DONE only needs to raise the strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else if (w_capture) begin
            if (w_exc) begin
                r_wb_rd   <= REG_W'(RSTATUS_REG);
                r_wb_data <= r_is_div ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MULT_EXC_CODE);
            end else begin
                r_wb_rd   <= r_rd;
                r_wb_data <= md_result;
            end
        end
    end

    assign md_operand_a = r_op_a;
    assign md_operand_b = r_op_b;
    assign md_ctrl_mult = (r_state == ST_START) && !r_is_div;
    assign md_ctrl_div  = (r_state == ST_START) && r_is_div;
    assign stall        = reset_n && (w_accept || (r_state == ST_START) || (r_state == ST_WAIT));
    assign wb_valid     = (r_state == ST_DONE);
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign busy         = (r_state != ST_IDLE);
    assign dbg_state    = r_state;

endmodule
